// File: rtl/dc_req_pkg.sv
// rtl/dc_req_pkg.sv - shared types and defaults for the DC data-bank requester
package dc_req_pkg;

  localparam int DC_MAX_OUT    = 4;
  localparam int DC_STARVE_MAX = 4;

  typedef logic [21:0] dc_addr_t;
  typedef logic [4:0]  dc_ldid_t;
  typedef logic [6:0]  dc_stid_t;

  typedef struct packed {
    logic [3:0]  valid;
    logic [31:0] data;
  } dc_word_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } dc_req_state_e;

endpackage

// File: rtl/dc_req_skid.sv
// rtl/dc_req_skid.sv - two-entry valid/retry skid buffer
//
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   in_valid_i/in_retry_o  upstream handshake; retry while both entries are full
//   in_data_i              upstream payload
//   out_valid_o/out_retry_i downstream handshake; head entry drives out_data_o
//   count_o                number of occupied entries (0..2)
module dc_req_skid #(
  parameter int W = 36
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid_i,
  output logic         in_retry_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_retry_i,
  output logic [W-1:0] out_data_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] e0_q, e1_q;
  logic [1:0]   cnt_q;
  logic         push, pop;

  // Retry depends only on the registered count, so a pop in the same cycle
  // never lets a third entry in.
  assign in_retry_o  = (cnt_q == 2'd2);
  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = e0_q;
  assign count_o     = cnt_q;

  assign push = in_valid_i & ~in_retry_o;
  assign pop  = out_valid_o & ~out_retry_i;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= 2'd0;
      e0_q  <= '0;
      e1_q  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) e0_q <= in_data_i;
          else               e1_q <= in_data_i;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          e0_q  <= e1_q;
          cnt_q <= cnt_q - 2'd1;
        end
        // Push and pop together only happens with one entry held: the new
        // word simply replaces the departing head.
        2'b11: e0_q <= in_data_i;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dc_databank_requester.sv
// rtl/dc_databank_requester.sv - load/store request initiator for the DC data array
//
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   ld_* / st_*                LSU load and store-data requests (valid/retry)
//   req_*, write, way          request to the data array, held under req_retry
//   Load_req*, STD_req*        ID of the issued load / store
//   ack_valid/ack_retry/ack_data  load data returning from the array
//   ld_ack_*                   load result to the LSU, ID from in-order FIFO
module dc_databank_requester
  import dc_req_pkg::*;
#(
  parameter int MAX_OUT    = DC_MAX_OUT,
  parameter int STARVE_MAX = DC_STARVE_MAX
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_valid,
  output logic        ld_retry,
  input  logic [21:0] ld_addr,
  input  logic [2:0]  ld_way,
  input  logic [4:0]  ld_id,
  input  logic        st_valid,
  output logic        st_retry,
  input  logic [21:0] st_addr,
  input  logic [2:0]  st_way,
  input  logic [31:0] st_data,
  input  logic [3:0]  st_bmask,
  input  logic [6:0]  st_id,
  output logic        req_valid,
  input  logic        req_retry,
  output logic        write,
  output logic [2:0]  way,
  output logic [21:0] req_addr,
  output logic [35:0] req_data,
  output logic [4:0]  Load_req,
  output logic        Load_req_valid,
  output logic [6:0]  STD_req,
  output logic        STD_req_valid,
  input  logic        ack_valid,
  output logic        ack_retry,
  input  logic [35:0] ack_data,
  output logic        ld_ack_valid,
  input  logic        ld_ack_retry,
  output logic [31:0] ld_ack_data,
  output logic [4:0]  ld_ack_id,
  output logic        ld_ack_partial
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  dc_req_state_e state_q;
  logic          h_write_q;
  logic [2:0]    h_way_q;
  dc_addr_t      h_addr_q;
  logic [35:0]   h_data_q;
  dc_ldid_t      h_ldid_q;
  dc_stid_t      h_stid_q;
  logic [SW-1:0] starve_q;

  // In-order load-ID FIFO; its occupancy is the outstanding-load count.
  dc_ldid_t      fifo_q [MAX_OUT];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;

  logic          idle, st_force, ld_win, st_win, ld_pop;
  logic [35:0]   skid_data;
  logic [1:0]    skid_cnt;
  dc_word_t      head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
  endfunction

  assign idle     = (state_q == IDLE);
  assign st_force = st_valid && (starve_q == SW'(STARVE_MAX));
  assign ld_win   = idle && ld_valid && (cnt_q != CW'(MAX_OUT)) && !st_force;
  assign st_win   = idle && st_valid && !ld_win;
  assign ld_retry = idle ? (ld_valid && !ld_win) : 1'b1;
  assign st_retry = idle ? (st_valid && !st_win) : 1'b1;

  always_comb begin
    req_valid = 1'b0;
    write     = 1'b0;
    way       = '0;
    req_addr  = '0;
    req_data  = '0;
    Load_req  = '0;
    STD_req   = '0;
    if (!idle) begin
      req_valid = 1'b1;
      write     = h_write_q;
      way       = h_way_q;
      req_addr  = h_addr_q;
      req_data  = h_data_q;
      Load_req  = h_ldid_q;
      STD_req   = h_stid_q;
    end else if (ld_win) begin
      req_valid = 1'b1;
      way       = ld_way;
      req_addr  = ld_addr;
      Load_req  = ld_id;
    end else if (st_win) begin
      req_valid = 1'b1;
      write     = 1'b1;
      way       = st_way;
      req_addr  = st_addr;
      req_data  = {st_bmask, st_data};
      STD_req   = st_id;
    end
  end

  assign Load_req_valid = req_valid & ~write;
  assign STD_req_valid  = req_valid & write;

  dc_req_skid #(.W(36)) u_ack_skid (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (ack_valid),
    .in_retry_o  (ack_retry),
    .in_data_i   (ack_data),
    .out_valid_o (ld_ack_valid),
    .out_retry_i (ld_ack_retry),
    .out_data_o  (skid_data),
    .count_o     (skid_cnt)
  );

  assign head           = dc_word_t'(skid_data);
  assign ld_pop         = ld_ack_valid & ~ld_ack_retry;
  assign ld_ack_data    = ld_ack_valid ? head.data : 32'd0;
  assign ld_ack_partial = ld_ack_valid & ~&head.valid;
  assign ld_ack_id      = ld_ack_valid ? fifo_q[rd_ptr_q] : 5'd0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      h_write_q <= 1'b0;
      h_way_q   <= '0;
      h_addr_q  <= '0;
      h_data_q  <= '0;
      h_ldid_q  <= '0;
      h_stid_q  <= '0;
      starve_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      for (int i = 0; i < MAX_OUT; i++) fifo_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // The LSU handshake already completed, so a retried request must
          // be captured and replayed from here.
          if (req_valid && req_retry) begin
            state_q   <= HOLD;
            h_write_q <= write;
            h_way_q   <= way;
            h_addr_q  <= req_addr;
            h_data_q  <= req_data;
            h_ldid_q  <= Load_req;
            h_stid_q  <= STD_req;
          end
        end
        HOLD: if (!req_retry) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      if (st_win)
        starve_q <= '0;
      else if (ld_win && st_valid && starve_q != SW'(STARVE_MAX))
        starve_q <= starve_q + 1'b1;

      if (ld_win) begin
        fifo_q[wr_ptr_q] <= ld_id;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (ld_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q <= cnt_q + CW'(ld_win) - CW'(ld_pop);
    end
  end

  // Every returning ack must belong to a load not already waiting in the skid.
  a_ack_has_id: assert property (@(posedge clk) disable iff (!reset)
    ack_valid |-> (CW'(skid_cnt) < cnt_q));

endmodule

// File: tb/tb_dc_databank_requester.sv
// tb/tb_dc_databank_requester.sv - directed self-checking bench for dc_databank_requester
module tb_dc_databank_requester;

  logic        clk, reset;
  logic        ld_valid, ld_retry;
  logic [21:0] ld_addr;
  logic [2:0]  ld_way;
  logic [4:0]  ld_id;
  logic        st_valid, st_retry;
  logic [21:0] st_addr;
  logic [2:0]  st_way;
  logic [31:0] st_data;
  logic [3:0]  st_bmask;
  logic [6:0]  st_id;
  logic        req_valid, req_retry, write;
  logic [2:0]  way;
  logic [21:0] req_addr;
  logic [35:0] req_data;
  logic [4:0]  Load_req;
  logic        Load_req_valid;
  logic [6:0]  STD_req;
  logic        STD_req_valid;
  logic        ack_valid, ack_retry;
  logic [35:0] ack_data;
  logic        ld_ack_valid, ld_ack_retry;
  logic [31:0] ld_ack_data;
  logic [4:0]  ld_ack_id;
  logic        ld_ack_partial;

  dc_databank_requester dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_retry(ld_retry), .ld_addr(ld_addr), .ld_way(ld_way), .ld_id(ld_id),
    .st_valid(st_valid), .st_retry(st_retry), .st_addr(st_addr), .st_way(st_way),
    .st_data(st_data), .st_bmask(st_bmask), .st_id(st_id),
    .req_valid(req_valid), .req_retry(req_retry), .write(write), .way(way),
    .req_addr(req_addr), .req_data(req_data),
    .Load_req(Load_req), .Load_req_valid(Load_req_valid),
    .STD_req(STD_req), .STD_req_valid(STD_req_valid),
    .ack_valid(ack_valid), .ack_retry(ack_retry), .ack_data(ack_data),
    .ld_ack_valid(ld_ack_valid), .ld_ack_retry(ld_ack_retry), .ld_ack_data(ld_ack_data),
    .ld_ack_id(ld_ack_id), .ld_ack_partial(ld_ack_partial)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    ld_valid = 0; ld_addr = 0; ld_way = 0; ld_id = 0;
    st_valid = 0; st_addr = 0; st_way = 0; st_data = 0; st_bmask = 0; st_id = 0;
    req_retry = 0; ack_valid = 0; ack_data = 0; ld_ack_retry = 0;
  endtask

  task automatic do_reset;
    reset = 0;
    idle_inputs();
    tick();
    reset = 1;
  endtask

  task automatic load(input logic [4:0] id);
    ld_valid = 1; ld_id = id; ld_addr = {15'd0, id, 2'b00}; ld_way = 3'd1;
    #2;
    chk("load_accept", ld_retry, 0);
    chk("load_req_id", Load_req, id);
    tick();
    ld_valid = 0;
  endtask

  typedef struct packed {
    logic       ld_v, st_v, ack_v;
    logic [4:0] ack_id;
    logic       ex_req_v, ex_write, ex_ld_retry, ex_st_retry, ex_lav;
    logic [4:0] ex_laid;
  } vec_t;

  vec_t tbl [12];

  initial begin
    // Continuous loads and stores; the array acks each load one cycle after issue.
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd1};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd2};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd6};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd7};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};

    reset = 0;
    idle_inputs();
    tick();
    tick();
    reset = 1;

    // Reset state
    #2;
    chk("rst_req_valid", req_valid, 0);
    chk("rst_ld_retry", ld_retry, 0);
    chk("rst_st_retry", st_retry, 0);
    chk("rst_ack_retry", ack_retry, 0);
    chk("rst_ld_ack_valid", ld_ack_valid, 0);
    chk("rst_req_addr", req_addr, 0);
    chk("rst_req_data", req_data, 0);
    chk("rst_load_req", Load_req, 0);
    chk("rst_std_req", STD_req, 0);
    tick();

    // Single load, array latency 2
    ld_valid = 1; ld_addr = 22'h00184; ld_way = 3'd2; ld_id = 5'd3;
    #2;
    chk("t1_req_valid", req_valid, 1);
    chk("t1_write", write, 0);
    chk("t1_way", way, 2);
    chk("t1_addr", req_addr, 22'h00184);
    chk("t1_data", req_data, 0);
    chk("t1_load_req", Load_req, 3);
    chk("t1_load_req_valid", Load_req_valid, 1);
    chk("t1_std_req_valid", STD_req_valid, 0);
    chk("t1_ld_retry", ld_retry, 0);
    tick();
    ld_valid = 0;
    tick();
    ack_valid = 1; ack_data = {4'hF, 32'hDEADBEEF};
    #2;
    chk("t1_no_early_ack", ld_ack_valid, 0);
    tick();
    ack_valid = 0;
    #2;
    chk("t1_ack_valid", ld_ack_valid, 1);
    chk("t1_ack_data", ld_ack_data, 32'hDEADBEEF);
    chk("t1_ack_id", ld_ack_id, 3);
    chk("t1_ack_partial", ld_ack_partial, 0);
    tick();
    #2;
    chk("t1_ack_drained", ld_ack_valid, 0);
    tick();

    // Store held under req_retry for 3 cycles; a second store waits behind it
    do_reset();
    st_valid = 1; st_addr = 22'h00AB4; st_way = 3'd5; st_data = 32'h12345678;
    st_bmask = 4'h3; st_id = 7'h41; req_retry = 1;
    #2;
    chk("t2_st_retry_accept", st_retry, 0);
    chk("t2_write", write, 1);
    chk("t2_std_req_valid", STD_req_valid, 1);
    tick();
    st_data = 32'hCAFEF00D; st_bmask = 4'hF; st_id = 7'h42; st_addr = 22'h00100;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) req_retry = 0;
      #2;
      chk("t2_hold_valid", req_valid, 1);
      chk("t2_hold_data", req_data, 36'h3_12345678);
      chk("t2_hold_addr", req_addr, 22'h00AB4);
      chk("t2_hold_way", way, 5);
      chk("t2_hold_std_req", STD_req, 7'h41);
      chk("t2_hold_st_retry", st_retry, 1);
      chk("t2_hold_ld_retry", ld_retry, 1);
      tick();
    end
    #2;
    chk("t2_next_st_retry", st_retry, 0);
    chk("t2_next_std_req", STD_req, 7'h42);
    chk("t2_next_data", req_data, 36'hF_CAFEF00D);
    tick();
    idle_inputs();

    // Outstanding limit: fifth load retried until a pop frees a slot
    do_reset();
    for (int i = 1; i <= 4; i++) load(5'(i));
    ld_valid = 1; ld_id = 5'd5; ld_addr = 22'h00014;
    ack_valid = 1; ack_data = {4'hF, 32'h11111111};
    #2;
    chk("t3_fifth_retry", ld_retry, 1);
    chk("t3_no_req", req_valid, 0);
    tick();
    ack_valid = 0;
    #2;
    chk("t3_retry_during_pop", ld_retry, 1);
    chk("t3_pop_valid", ld_ack_valid, 1);
    chk("t3_pop_id", ld_ack_id, 1);
    tick();
    #2;
    chk("t3_fifth_accept", ld_retry, 0);
    chk("t3_fifth_id", Load_req, 5);
    tick();
    idle_inputs();

    // Starvation: table-driven
    do_reset();
    st_addr = 22'h00200; st_way = 3'd4; st_data = 32'h5A5A5A5A; st_bmask = 4'hF; st_id = 7'h55;
    for (int r = 0; r < 12; r++) begin
      ld_valid  = tbl[r].ld_v;
      st_valid  = tbl[r].st_v;
      ld_id     = 5'(r);
      ld_addr   = 22'(r * 4);
      ack_valid = tbl[r].ack_v;
      ack_data  = {4'hF, 32'hA0000000 | 32'(tbl[r].ack_id)};
      #2;
      chk($sformatf("t4_r%0d_req_valid", r), req_valid, tbl[r].ex_req_v);
      chk($sformatf("t4_r%0d_write", r), write, tbl[r].ex_write);
      chk($sformatf("t4_r%0d_ld_retry", r), ld_retry, tbl[r].ex_ld_retry);
      chk($sformatf("t4_r%0d_st_retry", r), st_retry, tbl[r].ex_st_retry);
      chk($sformatf("t4_r%0d_ld_ack_valid", r), ld_ack_valid, tbl[r].ex_lav);
      if (tbl[r].ex_lav) begin
        chk($sformatf("t4_r%0d_ack_id", r), ld_ack_id, tbl[r].ex_laid);
        chk($sformatf("t4_r%0d_ack_data", r), ld_ack_data, 32'hA0000000 | 32'(tbl[r].ex_laid));
      end
      if (tbl[r].ex_req_v && !tbl[r].ex_write)
        chk($sformatf("t4_r%0d_load_req", r), Load_req, 5'(r));
      if (tbl[r].ex_req_v && tbl[r].ex_write)
        chk($sformatf("t4_r%0d_std_req", r), STD_req, 7'h55);
      tick();
    end
    idle_inputs();

    // Skid buffer under LSU back-pressure
    do_reset();
    load(5'd7); load(5'd8); load(5'd9);
    ld_ack_retry = 1;
    ack_valid = 1; ack_data = {4'hF, 32'hAAAA0007};
    #2;
    chk("t5_h0_ack_retry", ack_retry, 0);
    chk("t5_h0_lav", ld_ack_valid, 0);
    tick();
    ack_data = {4'hF, 32'hBBBB0008};
    #2;
    chk("t5_h1_ack_retry", ack_retry, 0);
    chk("t5_h1_lav", ld_ack_valid, 1);
    tick();
    ack_data = {4'h7, 32'hCCCC0009};
    #2;
    chk("t5_h2_ack_retry", ack_retry, 1);
    tick();
    #2;
    chk("t5_h3_ack_retry", ack_retry, 1);
    tick();
    ld_ack_retry = 0;
    #2;
    chk("t5_h4_ack_retry", ack_retry, 1);
    chk("t5_h4_id", ld_ack_id, 7);
    chk("t5_h4_data", ld_ack_data, 32'hAAAA0007);
    chk("t5_h4_partial", ld_ack_partial, 0);
    tick();
    #2;
    chk("t5_h5_ack_retry", ack_retry, 0);
    chk("t5_h5_id", ld_ack_id, 8);
    chk("t5_h5_data", ld_ack_data, 32'hBBBB0008);
    tick();
    ack_valid = 0;
    #2;
    chk("t5_h6_lav", ld_ack_valid, 1);
    chk("t5_h6_id", ld_ack_id, 9);
    chk("t5_h6_data", ld_ack_data, 32'hCCCC0009);
    chk("t5_h6_partial", ld_ack_partial, 1);
    tick();
    #2;
    chk("t5_h7_lav", ld_ack_valid, 0);
    tick();

    // Reset while holding a request with a full skid buffer
    do_reset();
    ld_ack_retry = 1;
    load(5'd1);
    ack_valid = 1; ack_data = {4'hF, 32'h00000001};
    load(5'd2);
    ld_valid = 1; ld_id = 5'd3; ld_addr = 22'h0000C; req_retry = 1;
    ack_data = {4'hF, 32'h00000002};
    #2;
    chk("t6_hold_entry", req_valid, 1);
    tick();
    ld_valid = 0; ack_valid = 0;
    #2;
    chk("t6_in_hold", ld_retry, 1);
    chk("t6_hold_id", Load_req, 3);
    chk("t6_skid_full", ack_retry, 1);
    reset = 0;
    tick();
    reset = 1; req_retry = 0; ld_ack_retry = 0;
    #2;
    chk("t6_req_valid", req_valid, 0);
    chk("t6_lav", ld_ack_valid, 0);
    chk("t6_ack_retry", ack_retry, 0);
    chk("t6_ld_retry", ld_retry, 0);
    chk("t6_st_retry", st_retry, 0);
    chk("t6_addr", req_addr, 0);
    chk("t6_load_req", Load_req, 0);
    chk("t6_load_req_valid", Load_req_valid, 0);
    tick();
    for (int i = 10; i < 14; i++) load(5'(i));
    ld_valid = 1; ld_id = 5'd14;
    #2;
    chk("t6_cnt_limit", ld_retry, 1);
    tick();
    idle_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
